uart_sram_loader: RTL

Upstream loader between the UART byte receiver and the shared external SRAM port in the top-level. It packs received bytes pairwise into 16-bit words and writes them to consecutive SRAM addresses from a base address. It detects end-of-file by an inactivity timeout and signals completion, so the top-level can hand the SRAM to the decoder (M1/M2) and later to the VGA reader.

---
 rtl/uart_sram_loader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_sram_loader.sv
// Packs UART bytes (first byte = high half) into 16-bit words and writes them to
// consecutive SRAM addresses; an inactivity timeout after the last byte ends the session.
module uart_sram_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter logic [17:0] BASE_ADDRESS   = 18'd0,
  parameter logic [17:0] MAX_WORDS      = 18'd262143
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        enable,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_frame_error,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        busy,
  output logic        done,
  output logic [17:0] word_count,
  output logic        frame_error,
  output logic        overflow
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LD_IDLE,
    S_LD_WAIT_HI,
    S_LD_WAIT_LO,
    S_LD_WRITE,
    S_LD_DONE
  } state_t;

  state_t           state, nxt_state;
  logic             enable_q;
  logic             started, nxt_started;
  logic             pad, nxt_pad;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [7:0]       hold, nxt_hold;
  logic [17:0]      nxt_address, nxt_count;
  logic [15:0]      nxt_wdata;
  logic             nxt_we_n, nxt_busy, nxt_done, nxt_ferr, nxt_ovf;
  logic             fire;

  // The idle timer only runs once the session has seen its first byte.
  assign fire = started && (cnt == CNT_LAST);

  always_comb begin
    nxt_state   = state;
    nxt_address = SRAM_address;
    nxt_wdata   = SRAM_write_data;
    nxt_we_n    = 1'b1;
    nxt_busy    = busy;
    nxt_done    = 1'b0;
    nxt_count   = word_count;
    nxt_ferr    = frame_error;
    nxt_ovf     = overflow;
    nxt_started = started;
    nxt_pad     = pad;
    nxt_hold    = hold;
    nxt_cnt     = cnt;

    if (started && (state inside {S_LD_WAIT_HI, S_LD_WAIT_LO, S_LD_WRITE}) && (cnt != CNT_LAST))
      nxt_cnt = cnt + CNT_W'(1);

    case (state)
      S_LD_IDLE: begin
        if (enable && !enable_q) begin
          nxt_address = BASE_ADDRESS;
          nxt_count   = '0;
          nxt_ferr    = 1'b0;
          nxt_ovf     = 1'b0;
          nxt_busy    = 1'b1;
          nxt_started = 1'b0;
          nxt_pad     = 1'b0;
          nxt_cnt     = '0;
          nxt_state   = S_LD_WAIT_HI;
        end
      end
      S_LD_WAIT_HI: begin
        if (!enable) begin
          nxt_busy  = 1'b0;
          nxt_state = S_LD_IDLE;
        end else if (rx_valid) begin
          nxt_hold    = rx_data;
          nxt_started = 1'b1;
          nxt_cnt     = '0;
          nxt_ferr    = frame_error | rx_frame_error;
          nxt_state   = S_LD_WAIT_LO;
        end else if (fire) begin
          nxt_done  = 1'b1;
          nxt_state = S_LD_DONE;
        end
      end
      S_LD_WAIT_LO: begin
        if (!enable) begin
          nxt_busy  = 1'b0;
          nxt_state = S_LD_IDLE;
        end else if (rx_valid) begin
          nxt_wdata = {hold, rx_data};
          nxt_we_n  = (word_count >= MAX_WORDS);
          nxt_cnt   = '0;
          nxt_ferr  = frame_error | rx_frame_error;
          nxt_pad   = 1'b0;
          nxt_state = S_LD_WRITE;
        end else if (fire) begin
          // Odd trailing byte: pad the low half and finish after this write.
          nxt_wdata = {hold, 8'h00};
          nxt_we_n  = (word_count >= MAX_WORDS);
          nxt_pad   = 1'b1;
          nxt_state = S_LD_WRITE;
        end
      end
      S_LD_WRITE: begin
        // The strobe is already on the bus this cycle, so bookkeeping happens even on abort.
        if (!SRAM_we_n) begin
          nxt_address = SRAM_address + 18'd1;
          nxt_count   = word_count + 18'd1;
        end else begin
          nxt_ovf = 1'b1;
        end
        if (!enable) begin
          nxt_busy  = 1'b0;
          nxt_state = S_LD_IDLE;
        end else if (pad) begin
          nxt_done  = 1'b1;
          nxt_state = S_LD_DONE;
        end else if (rx_valid) begin
          nxt_hold  = rx_data;
          nxt_cnt   = '0;
          nxt_ferr  = frame_error | rx_frame_error;
          nxt_state = S_LD_WAIT_LO;
        end else begin
          nxt_state = S_LD_WAIT_HI;
        end
      end
      S_LD_DONE: begin
        nxt_busy  = 1'b0;
        nxt_state = S_LD_IDLE;
      end
      default: nxt_state = S_LD_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state           <= S_LD_IDLE;
      enable_q        <= 1'b0;
      started         <= 1'b0;
      pad             <= 1'b0;
      cnt             <= '0;
      SRAM_address    <= BASE_ADDRESS;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      word_count      <= '0;
      frame_error     <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      state           <= nxt_state;
      enable_q        <= enable;
      started         <= nxt_started;
      pad             <= nxt_pad;
      cnt             <= nxt_cnt;
      SRAM_address    <= nxt_address;
      SRAM_write_data <= nxt_wdata;
      SRAM_we_n       <= nxt_we_n;
      busy            <= nxt_busy;
      done            <= nxt_done;
      word_count      <= nxt_count;
      frame_error     <= nxt_ferr;
      overflow        <= nxt_ovf;
    end
  end

  always_ff @(posedge CLOCK_50_I) begin
    hold <= nxt_hold;
  end

endmodule
